perf_counter_dump: RTL and testbench

- Collects per-cycle performance events into wrapping counters.
- On request, or periodically, atomically snapshots every counter and streams the snapshot out one record per cycle over a valid/ready interface.
- It is the read-out side of the core's perf-event counting: event producers only raise 1-bit strobes, and a trace/log sink consumes the records.
- Sits at core top level, beside the difftest/log infrastructure.

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_event_counter.sv | 29 ++
 rtl/perf_counter_dump.sv | 106 ++++++++++
 tb/tb_perf_counter_dump.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter dump block.
package perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } perf_state_t;

  localparam int unsigned NUM_EVENTS_DEF = 16;
  localparam int unsigned CNT_WIDTH_DEF  = 32;
  localparam int unsigned IDX_W          = $clog2(NUM_EVENTS_DEF);

  // One streamed record at the default configuration.
  typedef struct packed {
    logic [IDX_W-1:0]         idx;
    logic [CNT_WIDTH_DEF-1:0] data;
    logic                     last;
  } perf_record_t;

endpackage

// File: rtl/perf_event_counter.sv
// One wrapping event counter with its snapshot register.
module perf_event_counter #(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter bit          CLEAR_ON_DUMP = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clear,
  input  logic                 take,
  output logic [CNT_WIDTH-1:0] snap
);

  logic [CNT_WIDTH-1:0] cnt;

  // The snapshot takes the pre-increment value; a clear still beats a same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      snap <= '0;
    end else begin
      if (take) snap <= cnt;
      if (clear) cnt <= '0;
      else if (take && CLEAR_ON_DUMP) cnt <= CNT_WIDTH'(inc);
      else cnt <= cnt + CNT_WIDTH'(inc);
    end
  end

endmodule

// File: rtl/perf_counter_dump.sv
// Per-event wrapping counters with on-demand / periodic snapshot streamed over valid/ready.
module perf_counter_dump
  import perf_pkg::*;
#(
  parameter int unsigned NUM_EVENTS    = 16,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned PERIOD_WIDTH  = 16,
  parameter bit          CLEAR_ON_DUMP = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_EVENTS-1:0]         events_i,
  input  logic                          clear_i,
  input  logic                          dump_req_i,
  input  logic [PERIOD_WIDTH-1:0]       period_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_EVENTS)-1:0] out_idx,
  output logic [CNT_WIDTH-1:0]          out_data,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned   IW       = $clog2(NUM_EVENTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_EVENTS - 1);

  perf_state_t             state;
  logic [PERIOD_WIDTH-1:0] timer;
  logic                    pending;
  logic                    timer_hit;
  logic                    req;
  logic                    hs;
  logic                    take;
  logic [CNT_WIDTH-1:0]    snap [NUM_EVENTS];

  assign timer_hit = (period_i != '0) && (timer == period_i - 1'b1);
  assign req       = dump_req_i | timer_hit;
  assign hs        = out_valid & out_ready;
  assign out_last  = out_valid && (out_idx == LAST_IDX);
  assign busy      = (state == DUMP);
  assign out_data  = snap[out_idx];

  // Snapshot on an idle request, or on the final handshake when another dump is owed.
  assign take = (state == IDLE) ? req : (hs && out_last && (pending || req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (period_i == '0 || timer_hit) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      pending   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state     <= DUMP;
            out_valid <= 1'b1;
            out_idx   <= '0;
          end
        end
        DUMP: begin
          if (hs && out_last) begin
            pending <= 1'b0;
            out_idx <= '0;
            if (!(pending || req)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end else begin
            if (hs) out_idx <= out_idx + 1'b1;
            if (req) pending <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cnt
    perf_event_counter #(
      .CNT_WIDTH    (CNT_WIDTH),
      .CLEAR_ON_DUMP(CLEAR_ON_DUMP)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (events_i[g]),
      .clear(clear_i),
      .take (take),
      .snap (snap[g])
    );
  end

endmodule

// File: tb/tb_perf_counter_dump.sv
// Two instances (32-bit keep-on-dump, 8-bit clear-on-dump) checked against a record-queue model.
module tb_perf_counter_dump;

  localparam int N  = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  events = '0;
  logic          clear = 1'b0;
  logic          dump_req = 1'b0;
  logic [PW-1:0] period = '0;
  logic          out_ready = 1'b1;

  logic          v0, v1, l0, l1, b0, b1;
  logic [3:0]    i0, i1;
  logic [31:0]   d0;
  logic [7:0]    d1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perf_counter_dump #(.NUM_EVENTS(N), .CNT_WIDTH(32), .PERIOD_WIDTH(PW), .CLEAR_ON_DUMP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .events_i(events), .clear_i(clear), .dump_req_i(dump_req),
    .period_i(period), .out_valid(v0), .out_ready(out_ready), .out_idx(i0),
    .out_data(d0), .out_last(l0), .busy(b0));

  perf_counter_dump #(.NUM_EVENTS(N), .CNT_WIDTH(8), .PERIOD_WIDTH(PW), .CLEAR_ON_DUMP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .events_i(events), .clear_i(clear), .dump_req_i(dump_req),
    .period_i(period), .out_valid(v1), .out_ready(out_ready), .out_idx(i1),
    .out_data(d1), .out_last(l1), .busy(b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a dump is 16 queued records; a request during an unfinished dump owes one more.
  typedef struct {
    int unsigned idx;
    logic [31:0] a;
    logic [7:0]  b;
  } rec_t;

  rec_t        q[$];
  logic [31:0] ca [N];
  logic [7:0]  cb [N];
  int unsigned mtimer;
  bit          mpend;

  always @(posedge clk or posedge rst) begin : model
    bit req, hs, fin, take;
    int unsigned p;
    if (rst) begin
      q.delete();
      for (int i = 0; i < N; i++) begin
        ca[i] = '0;
        cb[i] = '0;
      end
      mtimer = 0;
      mpend  = 0;
    end else begin
      p      = int'(period);
      req    = dump_req || (p != 0 && mtimer == p - 1);
      mtimer = (p == 0 || mtimer == p - 1) ? 0 : mtimer + 1;
      hs     = (q.size() != 0) && out_ready;
      fin    = hs && (q.size() == 1);
      if (hs) void'(q.pop_front());
      take = 0;
      if (q.size() == 0) begin
        take  = req || (fin && mpend);
        mpend = 0;
      end else if (req) begin
        mpend = 1;
      end
      if (take)
        for (int i = 0; i < N; i++) q.push_back('{int'(i), ca[i], cb[i]});
      for (int i = 0; i < N; i++) begin
        ca[i] = clear ? 32'd0 : ca[i] + 32'(events[i]);
        cb[i] = clear ? 8'd0 : (take ? 8'(events[i]) : cb[i] + 8'(events[i]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid0", 32'(v0), 32'(q.size() != 0));
      check("valid1", 32'(v1), 32'(q.size() != 0));
      check("busy0", 32'(b0), 32'(q.size() != 0));
      check("busy1", 32'(b1), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("idx0", 32'(i0), q[0].idx);
        check("idx1", 32'(i1), q[0].idx);
        check("data0", d0, q[0].a);
        check("data1", 32'(d1), 32'(q[0].b));
        check("last0", 32'(l0), 32'(q[0].idx == N - 1));
        check("last1", 32'(l1), 32'(q[0].idx == N - 1));
      end
    end
  end

  task automatic drive(input logic [N-1:0] ev, input logic clr, input logic rq, input logic rdy);
    @(posedge clk);
    #2;
    events    = ev;
    clear     = clr;
    dump_req  = rq;
    out_ready = rdy;
  endtask

  task automatic do_reset(input logic [PW-1:0] per);
    @(posedge clk);
    #2;
    rst = 1'b1; events = '0; clear = 1'b0; dump_req = 1'b0; out_ready = 1'b1; period = per;
    #1;
    check("rst_valid", 32'(v0 | v1), 32'd0);
    check("rst_busy", 32'(b0 | b1), 32'd0);
    check("rst_last", 32'(l0 | l1), 32'd0);
    check("rst_idx", 32'({i0, i1}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic drain();
    events = '0; clear = 1'b0; dump_req = 1'b0; period = '0; out_ready = 1'b1;
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    check("drain_idle", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int hcount, nvalid, nstart, thr;
    int starts[$];
    logic [3:0]  pi;
    logic [31:0] pd;
    logic        prdy, pv;

    // Dump after five events on counter 3.
    do_reset('0);
    repeat (5) drive(16'h0008, 1'b0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t1_valid", 32'(v0), 32'd1);
      check("t1_idx", 32'(i0), 32'(k));
      check("t1_data", d0, (k == 3) ? 32'd5 : 32'd0);
      check("t1_last", 32'(l0), 32'(k == 15));
    end
    @(negedge clk);
    check("t1_busy_after", 32'(b0 | v0), 32'd0);

    // Request-cycle event excluded; a request mid-dump re-dumps with no bubble.
    drive('0, 1'b1, 1'b0, 1'b1);
    repeat (10) drive(16'h0001, 1'b0, 1'b0, 1'b1);
    drive(16'h0001, 1'b0, 1'b1, 1'b1);
    drive(16'h0001, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("t2_data0", d0, 32'd10);
        check("t2_data1", 32'(d1), 32'd10);
      end
      if (k == 5) dump_req = 1'b1;
      if (k == 6) dump_req = 1'b0;
      if (k == 16) begin
        check("t2_nobubble", 32'(v0), 32'd1);
        check("t2_redump_idx", 32'(i0), 32'd0);
        check("t2_redump0", d0, 32'd26);
        check("t2_redump1", 32'(d1), 32'd16);
      end
    end
    drain();

    // Ready pattern 1,0,0: records hold while stalled, 16 handshakes total.
    drive('0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    dump_req = 1'b0;
    hcount = 0; prdy = 1'b1; pi = '0; pd = '0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!v0) break;
      if (!prdy) begin
        check("t3_idx_hold", 32'(i0), 32'(pi));
        check("t3_data_hold", d0, pd);
      end
      out_ready = (t % 3 == 0);
      if (out_ready) hcount++;
      prdy = out_ready; pi = i0; pd = d0;
    end
    check("t3_handshakes", 32'(hcount), 32'd16);
    drain();

    // Periodic dumps every 40 cycles.
    do_reset(16'd40);
    pv = 1'b0;
    for (int n = 0; n < 130; n++) begin
      @(negedge clk);
      if (v0 && !pv) starts.push_back(n);
      pv = v0;
    end
    nstart = starts.size();
    check("t4_nstarts", 32'(nstart), 32'd3);
    if (nstart == 3) begin
      check("t4_start0", 32'(starts[0]), 32'd40);
      check("t4_start1", 32'(starts[1]), 32'd80);
      check("t4_start2", 32'(starts[2]), 32'd120);
    end

    // Back-pressure with period 10: exactly one merged re-dump, back to back.
    do_reset(16'd10);
    out_ready = 1'b0;
    repeat (50) @(negedge clk);
    out_ready = 1'b1;
    period = '0;
    nvalid = 0;
    for (int n = 0; n < 40; n++) begin
      if (!v0) break;
      if (nvalid == 16) check("t4_redump_idx0", 32'(i0), 32'd0);
      nvalid++;
      @(negedge clk);
    end
    check("t4_valid_run", 32'(nvalid), 32'd32);
    drain();

    // Clear mid-dump leaves the in-flight snapshot alone.
    do_reset('0);
    repeat (7) drive(16'h0004, 1'b0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) begin clear = 1'b1; events = 16'h0004; end
      if (k == 2) begin
        clear = 1'b0; events = '0;
        check("t5_inflight0", d0, 32'd7);
        check("t5_inflight1", 32'(d1), 32'd7);
      end
    end
    drain();
    drive('0, 1'b0, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 2) begin
        check("t5_cleared0", d0, 32'd0);
        check("t5_cleared1", 32'(d1), 32'd0);
      end
    end
    drain();

    // Wrap of the 8-bit counter, then reset in the middle of a dump.
    do_reset('0);
    repeat (256) drive(16'h0002, 1'b0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("t6_count0", d0, 32'd256);
        check("t6_wrap1", 32'(d1), 32'd0);
      end
      if (k == 6) begin
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(v0 | v1), 32'd0);
        check("t6_rst_busy", 32'(b0 | b1), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive('0, 1'b0, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t6_post_valid", 32'(v0), 32'd1);
      check("t6_post_data", d0 | 32'(d1), 32'd0);
    end
    drain();

    // Randomized traffic in segments with differing period and ready density.
    for (int seg = 0; seg < 8; seg++) begin
      @(posedge clk);
      #2;
      period = '0;
      @(posedge clk);
      #2;
      period = PW'($urandom_range(0, 40));
      thr = $urandom_range(1, 10);
      repeat (250) begin
        @(posedge clk);
        #2;
        events    = N'($urandom());
        clear     = ($urandom_range(0, 49) == 0);
        dump_req  = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 9) < thr);
      end
    end
    @(posedge clk);
    #2;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
